// File: rtl/fir_antialias.sv
// -----------------------------------------------------------------------------
// fir_antialias
// Serial-MAC FIR low-pass filter placed directly in front of the decimator.
// One input sample is accepted, then a single multiplier walks all NUM_TAPS
// taps (one tap per clock), and one rounded, saturated output sample is
// presented on a valid/ready port.
//
// Optional feature macro: COEF_LOAD_EN
//   defined   -> coef_* write port; coefficients live in registers
//   undefined -> coefficients are the constant moving-average default
//
// Ports
//   clk        in   1                  system clock
//   reset      in   1                  synchronous reset, active-low
//   x_valid    in   1                  input sample valid
//   x_ready    out  1                  block can accept a sample (IDLE only)
//   x_data     in   W                  signed input sample
//   y_valid    out  1                  filtered sample valid
//   y_ready    in   1                  downstream ready
//   y_data     out  W                  signed filtered sample
//   coef_we    in   1                  (COEF_LOAD_EN) coefficient write strobe
//   coef_addr  in   $clog2(NUM_TAPS)   (COEF_LOAD_EN) tap index
//   coef_data  in   COEF_W             (COEF_LOAD_EN) signed coefficient
//   coef_busy  out  1                  (COEF_LOAD_EN) high outside IDLE
// -----------------------------------------------------------------------------
module fir_antialias #(
    parameter int W         = 16,
    parameter int NUM_TAPS  = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic signed [W-1:0]         x_data,
    output logic                        y_valid,
    input  logic                        y_ready,
`ifdef COEF_LOAD_EN
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0]    coef_data,
    output logic                        coef_busy,
`endif
    output logic signed [W-1:0]         y_data
);

    localparam int TW     = $clog2(NUM_TAPS);
    localparam int PROD_W = W + COEF_W;
    localparam int ACC_W  = W + COEF_W + TW;

    localparam logic [TW-1:0]            LAST_TAP     = TW'(NUM_TAPS - 1);
    localparam logic signed [COEF_W-1:0] COEF_DEFAULT = COEF_W'((1 << COEF_FRAC) / NUM_TAPS);
    localparam logic signed [ACC_W-1:0]  RND          = ACC_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX      = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN      = -(ACC_W'(2 ** (W - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     rdy_q;
    logic                     y_valid_q;
    logic signed [W-1:0]      y_data_q;
    logic signed [ACC_W-1:0]  acc;
    logic [TW-1:0]            wptr;
    logic [TW-1:0]            tap;
    logic signed [W-1:0]      dl [NUM_TAPS];

    logic                     accept;
    logic [TW-1:0]            dl_idx;
    logic signed [W-1:0]      dl_sample;
    logic signed [COEF_W-1:0] coef_tap;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [W-1:0]      y_sat;

    assign x_ready = rdy_q;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign accept  = x_valid && rdy_q;

    // wptr has already advanced past the newest sample, so newest = wptr-1;
    // the power-of-two length makes the modulo a plain wrap of TW bits.
    assign dl_idx    = wptr - TW'(1) - tap;
    assign dl_sample = dl[dl_idx];
    assign prod      = PROD_W'(coef_tap) * PROD_W'(dl_sample);

    // -------------------------------------------------------------------------
    // Coefficient storage
    // -------------------------------------------------------------------------
`ifdef COEF_LOAD_EN
    logic signed [COEF_W-1:0] coef [NUM_TAPS];

    assign coef_busy = (state != IDLE);
    assign coef_tap  = coef[tap];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef[i] <= COEF_DEFAULT;
            end
        end else if (coef_we && (state == IDLE)) begin
            coef[coef_addr] <= coef_data;
        end
    end
`else
    assign coef_tap = COEF_DEFAULT;
`endif

    // -------------------------------------------------------------------------
    // Round half-up, then clamp to the output range
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        y_sat   = '0;
        rounded = (acc + RND) >>> COEF_FRAC;
        if (rounded > SAT_MAX) begin
            y_sat = W'(SAT_MAX);
        end else if (rounded < SAT_MIN) begin
            y_sat = W'(SAT_MIN);
        end else begin
            y_sat = rounded[W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = MAC;
            MAC:     if (tap == LAST_TAP) next_state = OUT;
            OUT:     if (y_valid_q && y_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, datapath and delay line
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            acc       <= '0;
            wptr      <= '0;
            tap       <= '0;
            // NOTE: the delay line is cleared on reset on purpose: a filter
            // restarted mid-stream must not blend stale history into the
            // first outputs.
            for (int i = 0; i < NUM_TAPS; i++) begin
                dl[i] <= '0;
            end
        end else begin
            state <= next_state;
            // Registered so x_ready is a clean function of state and stays
            // low through the reset cycles.
            rdy_q <= (next_state == IDLE);

            case (state)
                IDLE: begin
                    if (accept) begin
                        dl[wptr] <= x_data;
                        wptr     <= wptr + TW'(1);
                        acc      <= '0;
                        tap      <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    tap <= tap + TW'(1);
                end
                OUT: begin
                    // First OUT cycle captures the finished sum; afterwards
                    // the output holds until the downstream takes it.
                    if (!y_valid_q) begin
                        y_data_q  <= y_sat;
                        y_valid_q <= 1'b1;
                    end else if (y_ready) begin
                        y_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_antialias.sv
// -----------------------------------------------------------------------------
// tb_fir_antialias
// Self-checking bench for fir_antialias: reset state, a vector table of DC and
// impulse sequences, latency/backpressure, reset mid-MAC and (when
// COEF_LOAD_EN is defined) coefficient loading.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fir_antialias;

    localparam int W        = 16;
    localparam int NUM_TAPS = 16;
    localparam int TW       = $clog2(NUM_TAPS);

    logic                clk = 1'b0;
    logic                reset;
    logic                x_valid;
    logic                x_ready;
    logic signed [W-1:0] x_data;
    logic                y_valid;
    logic                y_ready;
    logic signed [W-1:0] y_data;
`ifdef COEF_LOAD_EN
    logic                coef_we   = 1'b0;
    logic [TW-1:0]       coef_addr = '0;
    logic signed [15:0]  coef_data = '0;
    logic                coef_busy;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_antialias #(.W(W), .NUM_TAPS(NUM_TAPS), .COEF_W(16), .COEF_FRAC(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
`ifdef COEF_LOAD_EN
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_busy (coef_busy),
`endif
        .y_data    (y_data)
    );

    typedef struct {
        bit                  rst;
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // All tasks begin and end just after a falling edge.
    task automatic do_reset();
        reset   = 1'b0;
        x_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Offer a sample; returns once it has been accepted.
    task automatic offer(input logic signed [W-1:0] x);
        int n = 0;
        x_valid = 1'b1;
        x_data  = x;
        while (!x_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) begin
            check("x_ready_timeout", 0, 1);
            x_valid = 1'b0;
            return;
        end
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    // Wait for an output (y_ready high) and consume it.
    task automatic recv(output logic signed [W-1:0] y);
        int n = 0;
        y_ready = 1'b1;
        while (!y_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!y_valid) begin
            check("y_valid_timeout", 0, 1);
            y = 'x;
            return;
        end
        y = y_data;
        @(negedge clk);
    endtask

    task automatic send(input logic signed [W-1:0] x, output logic signed [W-1:0] y);
        offer(x);
        recv(y);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [W-1:0] y;
        logic signed [W-1:0] hold;
        int                  lat;
        bit                  ok;

        // Vector table: DC of 1000 from reset, then a fresh impulse.
        for (int i = 0; i < 20; i++) begin
            vecs[i].rst = (i == 0);
            vecs[i].x   = 16'sd1000;
            vecs[i].y   = (i < 15) ? W'((125 * (i + 1) + 1) / 2) : 16'sd1000;
        end
        vecs[20].rst = 1'b1;
        vecs[20].x   = 16'sd32767;
        vecs[20].y   = 16'sd2048;
        for (int i = 21; i < NV; i++) begin
            vecs[i].rst = 1'b0;
            vecs[i].x   = 16'sd0;
            vecs[i].y   = (i < 36) ? 16'sd2048 : 16'sd0;
        end

        // ---- Reset held with x_valid asserted ----
        reset   = 1'b0;
        x_valid = 1'b1;
        x_data  = 16'sd1000;
        y_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_x_ready", x_ready, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        reset   = 1'b1;
        x_valid = 1'b0;
        @(negedge clk);
        check("rst_release_x_ready", x_ready, 1);

        // ---- Table-driven DC and impulse ----
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            send(vecs[i].x, y);
            check($sformatf("vec%0d", i), y, vecs[i].y);
        end

        // ---- Latency and backpressure ----
        do_reset();
        y_ready = 1'b0;
        x_valid = 1'b1;
        x_data  = 16'sd1000;
        @(posedge clk);
        #1 x_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!y_valid && lat < 100);
        check("latency_edges", lat, 17);
        check("latency_y_data", y_data, 63);

        hold    = y_data;
        x_valid = 1'b1;
        x_data  = 16'sd1000;
        ok      = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (y_data !== hold || y_valid !== 1'b1 || x_ready !== 1'b0) ok = 1'b0;
        end
        check("stall_stable", ok, 1);
        y_ready = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        check("stall_no_dup", y_valid, 0);
        send(16'sd1000, y);
        check("stall_next_sample", y, 125);

        // ---- Reset in the middle of the MAC phase ----
        do_reset();
        x_valid = 1'b1;
        x_data  = 16'sd1000;
        @(posedge clk);
        #1 x_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ok = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (y_valid) ok = 1'b1;
        end
        check("midmac_no_output", ok, 0);
        send(16'sd1000, y);
        check("midmac_cleared", y, 63);

`ifdef COEF_LOAD_EN
        // ---- Write while busy is ignored ----
        do_reset();
        offer(16'sd1000);
        check("coef_busy_in_mac", coef_busy, 1);
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 16'sd0;
        @(negedge clk);
        coef_we = 1'b0;
        recv(y);
        check("busy_write_out1", y, 63);
        send(16'sd1000, y);
        check("busy_write_out2", y, 125);

        // ---- Load all taps to 32767 and saturate ----
        do_reset();
        check("coef_busy_idle", coef_busy, 0);
        for (int i = 0; i < NUM_TAPS; i++) begin
            coef_we   = 1'b1;
            coef_addr = TW'(i);
            coef_data = 16'sd32767;
            @(negedge clk);
        end
        coef_we = 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            send(16'sd32767, y);
            if (i == 0) check("load_first", y, 32766);
        end
        check("load_sat_pos", y, 32767);
        for (int i = 0; i < NUM_TAPS; i++) begin
            send(-16'sd32768, y);
        end
        check("load_sat_neg", y, -32768);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
